// File: rtl/complex_mult_scoreboard.sv
// Self-checking scoreboard for a complex multiplier: predicts a*c-b*d / a*d+b*c per accepted operand and checks results in order.
// Latency: counters, pending, flags and mismatch_pulse update on the handshake edge (visible the next cycle).
// Backpressure: none exerted; passively taps op/res handshakes, overflow drops the entry and sets a sticky flag.
//
// Ports:
//   clk, rst (async, active-high), sw_rst (sync clear)
//   op_val/op_ready/op_data   : operand tap, op_data = {a, b, c, d}
//   res_val/res_ready/res_data: result tap, res_data = {tag[3:0], re, im}
//   match_cnt, mismatch_cnt   : saturating 16-bit check counters
//   mismatch_pulse            : one-cycle pulse after a failing pop
//   pending                   : expected-FIFO occupancy
//   err_overflow, err_underflow: sticky protocol errors
module complex_mult_scoreboard #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int SIGNED     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sw_rst,
    input  logic                           op_val,
    input  logic                           op_ready,
    input  logic [4*DATA_WIDTH-1:0]        op_data,
    input  logic                           res_val,
    input  logic                           res_ready,
    input  logic [4*DATA_WIDTH+3:0]        res_data,
    output logic [15:0]                    match_cnt,
    output logic [15:0]                    mismatch_cnt,
    output logic                           mismatch_pulse,
    output logic [$clog2(DEPTH):0]         pending,
    output logic                           err_overflow,
    output logic                           err_underflow
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * PW + 4;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Expected-result storage; contents are don't-care after reset, so no reset here.
    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [3:0]    tag_q, tag_d;
    logic [15:0]   match_cnt_q, match_cnt_d;
    logic [15:0]   mismatch_cnt_q, mismatch_cnt_d;
    logic          mismatch_pulse_q, mismatch_pulse_d;
    logic          err_overflow_q, err_overflow_d;
    logic          err_underflow_q, err_underflow_d;

    logic          push_hs, pop_hs, empty, full, do_push, do_pop, entry_match;
    logic [PW-1:0] a_x, b_x, c_x, d_x, exp_re, exp_im;
    logic [EW-1:0] push_entry, head_entry;

    function automatic logic [PW-1:0] extend(input logic [DW-1:0] x);
        // Sign- or zero-extension to product width; products are then taken modulo 2^PW,
        // which gives the same low bits as a full-precision multiply.
        if (SIGNED != 0) return {{DW{x[DW-1]}}, x};
        else             return {{DW{1'b0}}, x};
    endfunction

    always_comb begin
        a_x    = extend(op_data[4*DW-1:3*DW]);
        b_x    = extend(op_data[3*DW-1:2*DW]);
        c_x    = extend(op_data[2*DW-1:DW]);
        d_x    = extend(op_data[DW-1:0]);
        exp_re = (a_x * c_x) - (b_x * d_x);
        exp_im = (a_x * d_x) + (b_x * c_x);
        push_entry = {tag_q, exp_re, exp_im};
    end

    assign push_hs    = op_val && op_ready;
    assign pop_hs     = res_val && res_ready;
    assign empty      = (count_q == '0);
    assign full       = (count_q == FULL_CNT);
    assign head_entry = mem_q[rd_ptr_q];
    assign entry_match = (head_entry == res_data);

    // A pop on an empty FIFO is an underflow and never frees a slot,
    // so a push into a full FIFO only proceeds alongside a real pop.
    assign do_pop  = pop_hs && !empty;
    assign do_push = push_hs && (!full || do_pop);

    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        tag_d            = tag_q;
        match_cnt_d      = match_cnt_q;
        mismatch_cnt_d   = mismatch_cnt_q;
        mismatch_pulse_d = 1'b0;
        err_overflow_d   = err_overflow_q;
        err_underflow_d  = err_underflow_q;

        if (sw_rst) begin
            wr_ptr_d        = '0;
            rd_ptr_d        = '0;
            count_d         = '0;
            tag_d           = '0;
            match_cnt_d     = '0;
            mismatch_cnt_d  = '0;
            err_overflow_d  = 1'b0;
            err_underflow_d = 1'b0;
        end else begin
            // Tag advances on every accepted operand, even a dropped one,
            // so the DUT-side sequence stays aligned with the operand stream.
            if (push_hs) tag_d = tag_q + 4'd1;
            if (push_hs && full && !do_pop) err_overflow_d = 1'b1;
            if (pop_hs && empty) err_underflow_d = 1'b1;

            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (entry_match) begin
                    if (match_cnt_q != 16'hFFFF) match_cnt_d = match_cnt_q + 16'd1;
                end else begin
                    if (mismatch_cnt_q != 16'hFFFF) mismatch_cnt_d = mismatch_cnt_q + 16'd1;
                    mismatch_pulse_d = 1'b1;
                end
            end

            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            tag_q            <= '0;
            match_cnt_q      <= '0;
            mismatch_cnt_q   <= '0;
            mismatch_pulse_q <= 1'b0;
            err_overflow_q   <= 1'b0;
            err_underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            tag_q            <= tag_d;
            match_cnt_q      <= match_cnt_d;
            mismatch_cnt_q   <= mismatch_cnt_d;
            mismatch_pulse_q <= mismatch_pulse_d;
            err_overflow_q   <= err_overflow_d;
            err_underflow_q  <= err_underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !sw_rst) mem_q[wr_ptr_q] <= push_entry;
    end

    assign match_cnt      = match_cnt_q;
    assign mismatch_cnt   = mismatch_cnt_q;
    assign mismatch_pulse = mismatch_pulse_q;
    assign pending        = count_q;
    assign err_overflow   = err_overflow_q;
    assign err_underflow  = err_underflow_q;

endmodule

// File: tb/tb_complex_mult_scoreboard.sv
module tb_complex_mult_scoreboard;

    logic        clk = 1'b0;
    logic        rst, sw_rst;
    logic        op_val, op_ready, res_val, res_ready;
    logic [31:0] op_data;
    logic [35:0] res_data;

    logic [15:0] u_match, u_mismatch, s_match, s_mismatch;
    logic        u_pulse, u_ovf, u_unf, s_pulse, s_ovf, s_unf;
    logic [2:0]  u_pending, s_pending;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    complex_mult_scoreboard #(.DATA_WIDTH(8), .DEPTH(4), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .sw_rst(sw_rst),
        .op_val(op_val), .op_ready(op_ready), .op_data(op_data),
        .res_val(res_val), .res_ready(res_ready), .res_data(res_data),
        .match_cnt(u_match), .mismatch_cnt(u_mismatch), .mismatch_pulse(u_pulse),
        .pending(u_pending), .err_overflow(u_ovf), .err_underflow(u_unf)
    );

    complex_mult_scoreboard #(.DATA_WIDTH(8), .DEPTH(4), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .sw_rst(sw_rst),
        .op_val(op_val), .op_ready(op_ready), .op_data(op_data),
        .res_val(res_val), .res_ready(res_ready), .res_data(res_data),
        .match_cnt(s_match), .mismatch_cnt(s_mismatch), .mismatch_pulse(s_pulse),
        .pending(s_pending), .err_overflow(s_ovf), .err_underflow(s_unf)
    );

    function automatic logic [31:0] op(input logic [7:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    function automatic logic [35:0] res(input logic [3:0] tag, input logic [15:0] re, im);
        return {tag, re, im};
    endfunction

    // One clock: drive at negedge, posedge samples, outputs observed at the following negedge.
    task automatic step(input logic push, input logic [31:0] opd,
                        input logic pop, input logic [35:0] rd);
        op_val = push; op_ready = 1'b1; op_data = opd;
        res_val = pop; res_ready = 1'b1; res_data = rd;
        @(negedge clk);
        op_val = 1'b0; res_val = 1'b0;
    endtask

    task automatic pulse_sw_rst();
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({u_match, u_mismatch, u_pulse, u_pending, u_ovf, u_unf} !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h required 0",
                     {u_match, u_mismatch, u_pulse, u_pending, u_ovf, u_unf});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned_basic();
        // Valid without ready must be ignored on both sides.
        op_val = 1'b1; op_ready = 1'b0; op_data = op(3, 4, 5, 6);
        res_val = 1'b1; res_ready = 1'b0; res_data = res(0, 16'hFFF7, 16'h0026);
        @(negedge clk);
        op_val = 1'b0; res_val = 1'b0;
        vectors++;
        if (u_pending !== 3'd0 || u_unf !== 1'b0) begin
            miscompares++;
            $display("FAIL no_ready_ignored: pending=%0d unf=%b required 0/0", u_pending, u_unf);
        end
        step(1, op(3, 4, 5, 6), 0, '0);
        vectors++;
        if (u_pending !== 3'd1) begin
            miscompares++;
            $display("FAIL basic_push_pending: got %0d required 1", u_pending);
        end
        step(0, '0, 0, '0);
        step(0, '0, 1, res(0, 16'hFFF7, 16'h0026));
        vectors++;
        if (u_match !== 16'd1 || u_mismatch !== 16'd0 || u_pending !== 3'd0) begin
            miscompares++;
            $display("FAIL basic_match: match=%0d mismatch=%0d pending=%0d required 1/0/0",
                     u_match, u_mismatch, u_pending);
        end
    endtask

    task automatic test_signed();
        pulse_sw_rst();
        step(1, op(8'hFF, 8'h02, 8'h03, 8'hFC), 0, '0);
        step(0, '0, 1, res(0, 16'h0005, 16'h000A));
        vectors++;
        if (s_match !== 16'd1 || s_mismatch !== 16'd0) begin
            miscompares++;
            $display("FAIL signed_match: match=%0d mismatch=%0d required 1/0", s_match, s_mismatch);
        end
        vectors++;
        if (u_mismatch !== 16'd1 || u_pulse !== 1'b1 || u_match !== 16'd0) begin
            miscompares++;
            $display("FAIL unsigned_mismatch: mismatch=%0d pulse=%b match=%0d required 1/1/0",
                     u_mismatch, u_pulse, u_match);
        end
        step(0, '0, 0, '0);
        vectors++;
        if (u_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse_one_cycle: got %b required 0", u_pulse);
        end
        pulse_sw_rst();
        step(1, op(8'hFF, 8'h02, 8'h03, 8'hFC), 0, '0);
        step(0, '0, 1, res(0, 16'h0105, 16'hFB0A));
        vectors++;
        if (u_match !== 16'd1 || u_mismatch !== 16'd0) begin
            miscompares++;
            $display("FAIL unsigned_product: match=%0d mismatch=%0d required 1/0", u_match, u_mismatch);
        end
    endtask

    task automatic test_overflow();
        pulse_sw_rst();
        for (int i = 0; i < 5; i++) step(1, op(8'(i + 1), 0, 2, 0), 0, '0);
        vectors++;
        if (u_ovf !== 1'b1 || u_pending !== 3'd4) begin
            miscompares++;
            $display("FAIL overflow: ovf=%b pending=%0d required 1/4", u_ovf, u_pending);
        end
        for (int i = 0; i < 4; i++) step(0, '0, 1, res(4'(i), 16'(2 * (i + 1)), 16'h0000));
        vectors++;
        if (u_match !== 16'd4 || u_mismatch !== 16'd0 || u_pending !== 3'd0) begin
            miscompares++;
            $display("FAIL overflow_drain: match=%0d mismatch=%0d pending=%0d required 4/0/0",
                     u_match, u_mismatch, u_pending);
        end
    endtask

    task automatic test_tag_wrap();
        pulse_sw_rst();
        for (int k = 0; k <= 20; k++) begin
            step(k < 20, op(8'(k), 1, 2, 3),
                 k > 0, res(4'(k - 1), 16'(2 * (k - 1)) - 16'd3, 16'(3 * (k - 1) + 2)));
            if (k == 10) begin
                vectors++;
                if (u_pending !== 3'd1) begin
                    miscompares++;
                    $display("FAIL b2b_pending: got %0d required 1", u_pending);
                end
            end
        end
        vectors++;
        if (u_match !== 16'd20 || u_mismatch !== 16'd0 || u_ovf !== 1'b0 || u_unf !== 1'b0) begin
            miscompares++;
            $display("FAIL tag_wrap: match=%0d mismatch=%0d ovf=%b unf=%b required 20/0/0/0",
                     u_match, u_mismatch, u_ovf, u_unf);
        end
    endtask

    task automatic test_underflow();
        pulse_sw_rst();
        step(0, '0, 1, res(0, 16'h1234, 16'h5678));
        vectors++;
        if (u_unf !== 1'b1 || u_match !== 16'd0 || u_mismatch !== 16'd0 || u_pending !== 3'd0) begin
            miscompares++;
            $display("FAIL underflow: unf=%b match=%0d mismatch=%0d pending=%0d required 1/0/0/0",
                     u_unf, u_match, u_mismatch, u_pending);
        end
        // Zero-latency result: underflow, but the same-cycle push is kept.
        step(1, op(3, 4, 5, 6), 1, res(0, 16'hFFF7, 16'h0026));
        vectors++;
        if (u_pending !== 3'd1 || u_match !== 16'd0) begin
            miscompares++;
            $display("FAIL empty_push_pop: pending=%0d match=%0d required 1/0", u_pending, u_match);
        end
        step(0, '0, 1, res(0, 16'hFFF7, 16'h0026));
        vectors++;
        if (u_match !== 16'd1 || u_pending !== 3'd0) begin
            miscompares++;
            $display("FAIL empty_push_kept: match=%0d pending=%0d required 1/0", u_match, u_pending);
        end
    endtask

    task automatic test_full_push_pop();
        pulse_sw_rst();
        for (int i = 0; i < 4; i++) step(1, op(8'(i + 1), 0, 2, 0), 0, '0);
        step(1, op(5, 0, 2, 0), 1, res(0, 16'd2, 16'd0));
        vectors++;
        if (u_pending !== 3'd4 || u_ovf !== 1'b0 || u_match !== 16'd1) begin
            miscompares++;
            $display("FAIL full_push_pop: pending=%0d ovf=%b match=%0d required 4/0/1",
                     u_pending, u_ovf, u_match);
        end
        for (int i = 1; i < 5; i++) step(0, '0, 1, res(4'(i), 16'(2 * (i + 1)), 16'd0));
        vectors++;
        if (u_match !== 16'd5 || u_pending !== 3'd0) begin
            miscompares++;
            $display("FAIL full_drain: match=%0d pending=%0d required 5/0", u_match, u_pending);
        end
    endtask

    task automatic test_wrong_tag();
        pulse_sw_rst();
        step(1, op(3, 4, 5, 6), 0, '0);
        step(0, '0, 1, res(5, 16'hFFF7, 16'h0026));
        vectors++;
        if (u_mismatch !== 16'd1 || u_match !== 16'd0 || u_pulse !== 1'b1) begin
            miscompares++;
            $display("FAIL wrong_tag: mismatch=%0d match=%0d pulse=%b required 1/0/1",
                     u_mismatch, u_match, u_pulse);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1, op(1, 1, 1, 1), 0, '0);
        vectors++;
        if (u_pending !== 3'd3 || u_mismatch !== 16'd1) begin
            miscompares++;
            $display("FAIL pre_reset: pending=%0d mismatch=%0d required 3/1", u_pending, u_mismatch);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({u_match, u_mismatch, u_pulse, u_pending, u_ovf, u_unf} !== 38'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h required 0",
                     {u_match, u_mismatch, u_pulse, u_pending, u_ovf, u_unf});
        end
        @(negedge clk);
        rst = 1'b0;
        step(0, '0, 1, res(0, 16'h0000, 16'h0002));
        vectors++;
        if (u_unf !== 1'b1 || u_match !== 16'd0) begin
            miscompares++;
            $display("FAIL post_reset_underflow: unf=%b match=%0d required 1/0", u_unf, u_match);
        end
    endtask

    task automatic test_sw_rst();
        step(1, op(3, 4, 5, 6), 0, '0);
        step(1, op(3, 4, 5, 6), 0, '0);
        pulse_sw_rst();
        vectors++;
        if (u_pending !== 3'd0 || u_unf !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_rst_clear: pending=%0d unf=%b required 0/0", u_pending, u_unf);
        end
        step(1, op(3, 4, 5, 6), 0, '0);
        step(0, '0, 1, res(0, 16'hFFF7, 16'h0026));
        vectors++;
        if (u_match !== 16'd1 || u_mismatch !== 16'd0) begin
            miscompares++;
            $display("FAIL sw_rst_tag0: match=%0d mismatch=%0d required 1/0", u_match, u_mismatch);
        end
    endtask

    initial begin
        rst = 1'b1; sw_rst = 1'b0;
        op_val = 1'b0; op_ready = 1'b0; op_data = '0;
        res_val = 1'b0; res_ready = 1'b0; res_data = '0;
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_overflow();
        test_tag_wrap();
        test_underflow();
        test_full_push_pop();
        test_wrong_tag();
        test_async_reset();
        test_sw_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/complex_mult_scoreboard.md
# complex_mult_scoreboard

Parametrised, synthesisable self-checking scoreboard for the complex-number multiplier. It sits beside the DUT in the testbench and taps both handshake interfaces. For every accepted operand pair it computes the expected product and queues it, with a sequence tag, in a DEPTH-entry FIFO. Each accepted result is checked in order against the queue head, and the block maintains match/mismatch counters and sticky protocol-error flags.

## Interface
- DATA_WIDTH, 8: width of each real/imaginary operand component.
- DEPTH, 4: expected-result FIFO entries; power of two, ≥2.
- SIGNED, 0: 0 = operands and products unsigned; 1 = two's complement.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- sw_rst  in  1  synchronous clear; same effect as rst, lower priority than rst.
- op_val  in  1  operand valid (DUT input side).
- op_ready  in  1  operand ready (DUT input side).
- op_data  in  4*DATA_WIDTH  fields {a, b, c, d}, MSB first: operand 1 = a+jb, operand 2 = c+jd.
- res_val  in  1  result valid (DUT output side).
- res_ready  in  1  result ready (DUT output side).
- res_data  in  4*DATA_WIDTH+4  fields {tag[3:0], re[2*DW-1:0], im[2*DW-1:0]}, MSB first.
- match_cnt  out  16  count of fully correct results; saturates at 16'hFFFF.
- mismatch_cnt  out  16  count of results with a wrong re, im or tag; saturates.
- mismatch_pulse  out  1  one-cycle pulse, registered, on each mismatch.
- pending  out  $clog2(DEPTH)+1  current FIFO occupancy.
- err_overflow  out  1  sticky: operand accepted while FIFO full with no pop.
- err_underflow  out  1  sticky: result accepted while FIFO empty.

## Operation
- Push on op_val && op_ready. Computed entry:
  - exp_re = a*c − b*d
  - exp_im = a*d + b*c
  - Both computed at full precision and truncated to 2*DATA_WIDTH bits (modulo 2^(2*DW)).
  - SIGNED=1: fields sign-extended before multiplying.
  - exp_tag = 4-bit op sequence counter. It starts at 0, increments on every push (including a dropped push) and wraps 15→0.
- Pop on res_val && res_ready.
  - Compare res re, im and tag against the FIFO head, using FIFO state as it stood before the current edge.
  - All three fields equal → match_cnt+1; otherwise mismatch_cnt+1 and mismatch_pulse=1 on the next cycle.
- Handshake rules: op_val or res_val without the matching ready has no effect. Data is sampled only on the handshake cycle.
- FIFO boundary cases:
  - Full, push without pop: entry dropped, err_overflow set, pending stays DEPTH.
  - Full, push and pop in the same cycle: both performed, pending unchanged.
  - Empty, pop (with or without a same-cycle push): err_underflow set, no counter change. A same-cycle push is still stored.
  - Read and write pointers wrap modulo DEPTH.
- Reset (rst async, or sw_rst sync) clears:
  - FIFO pointers, pending, op sequence counter, both counters, mismatch_pulse and both sticky flags, all to 0.
  - FIFO contents need not be cleared.
- Reset mid-stream: entries in flight are discarded. The next result after reset is an underflow unless an operand was pushed first.
- Simulation only (translate_off): $display of time, expected and actual re/im/tag for each pop. "PASS" on a match, "FAIL" on a mismatch.

## Timing
- The output registers for counters, pending and flags change on the edge that samples the handshake. They are visible 1 cycle after that handshake.
- mismatch_pulse goes high for exactly 1 cycle, in the cycle after the failing pop.
- Back-to-back push and pop every cycle are supported with no bubbles.
- Minimum DUT latency checkable: 1 cycle, i.e. result handshake at least one edge after the operand handshake. A zero-latency result is an underflow by definition.
- Throughput: one push and one pop per cycle.

## Test plan
- Unsigned mode, DW=8, SIGNED=0:
  - Push (3+4j)·(5+6j).
  - Result {tag=0, re=16'hFFF7, im=16'h0026} two cycles later → match_cnt=1, mismatch_cnt=0, pending returns to 0.
- Signed mode, SIGNED=1:
  - Push a=8'hFF, b=2, c=3, d=8'hFC.
  - Expect re=16'h0005, im=16'h000A.
  - Same stimulus with SIGNED=0 expects re=16'h0105 instead; a result of 0x0005 in that build → mismatch_cnt=1 and a 1-cycle mismatch_pulse.
- Overflow/tag wrap, DEPTH=4:
  - Push 5 operands with no results → err_overflow=1, pending=4.
  - Then 4 results with tags 0..3 → match_cnt=4.
  - Separately, 20 push/pop pairs → tags wrap 15→0, all 20 match.
- Underflow and simultaneous events:
  - Result handshake while empty → err_underflow=1, counters unchanged.
  - Full FIFO with push and pop in the same cycle → pending stays 4, no overflow.
- Wrong tag: correct re/im with tag=5 when 0 is expected → mismatch_cnt=1.
- Reset:
  - Assert rst asynchronously (between edges) with pending=3 → all outputs 0 immediately.
  - Assert sw_rst for 1 cycle → same clear at the next edge; the following push gets tag 0.
